// File: rtl/data_memory_sized.sv
// data_memory_sized
//  Byte-addressed, little-endian data memory for the CPU load/store path.
//  One request at a time: a request is captured when ready is high, then the
//  block stays BUSY for LATENCY cycles before it executes the access and pulses valid.
// Ports
//  clk        clock, rising edge
//  rst_n      asynchronous reset, active low
//  memRead    load request
//  memWrite   store request
//  funct3     RV access size/sign code (B/H/W/D, BU/HU/WU)
//  address    byte address; bits above log2(DEPTH_BYTES) are ignored
//  writeData  store data, low 8/16/32/64 bits used per size
//  ready      request can be accepted this cycle
//  valid      one-cycle response strobe
//  readData   load result, extended to DATA_WIDTH; held between responses
//  error      with valid: request rejected (illegal, misaligned or unsupported)
module data_memory_sized #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned ADDR_WIDTH  = 48,
   parameter int unsigned DEPTH_BYTES = 256,
   parameter int unsigned LATENCY     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  error
);

   localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, BUSY} stateT;

   stateT             state;
   logic [CNT_W-1:0]  cnt;
   logic              opRead;
   logic              opWrite;
   logic [2:0]        opFunct3;
   logic [IDX_W-1:0]  opAddr;
   logic [63:0]       opData;

   logic [7:0]        mem [DEPTH_BYTES];

   logic              accept;
   logic              complete;
   logic              misaligned;
   logic              reqError;
   logic              doWrite;
   logic [7:0]        byteEn;
   logic [63:0]       rawWord;
   logic [63:0]       loadVal64;

   // Upper address bits only wrap; folded here so they are visibly consumed.
   logic              unusedAddrBits;
   assign unusedAddrBits = ^address[ADDR_WIDTH-1:IDX_W];

   assign accept   = (state == IDLE) && (memRead || memWrite);
   assign complete = (state == BUSY) && (cnt == '0);

   // Request decode on the captured operation.
   always_comb begin
      misaligned = 1'b0;
      byteEn     = 8'h00;
      case (opFunct3[1:0])
         2'd0: begin
            byteEn     = 8'h01;
         end
         2'd1: begin
            byteEn     = 8'h03;
            misaligned = opAddr[0];
         end
         2'd2: begin
            byteEn     = 8'h0F;
            misaligned = |opAddr[1:0];
         end
         default: begin
            byteEn     = 8'hFF;
            misaligned = |opAddr[2:0];
         end
      endcase

      reqError = (opRead && opWrite)
               || (opFunct3 == 3'b111)
               || ((DATA_WIDTH == 32) && ((opFunct3 == 3'b011) || (opFunct3 == 3'b110)))
               || misaligned;

      doWrite = complete && opWrite && !opRead && !reqError;
   end

   // Gather up to eight bytes from the access address, wrapping in the array.
   always_comb begin
      rawWord = '0;
      for (int i = 0; i < 8; i++) begin
         rawWord[8*i +: 8] = mem[opAddr + IDX_W'(i)];
      end
   end

   // Size and sign extension, built at 64 bits and trimmed to the bus width.
   always_comb begin
      loadVal64 = '0;
      case (opFunct3)
         3'b000:  loadVal64 = {{56{rawWord[7]}},  rawWord[7:0]};
         3'b001:  loadVal64 = {{48{rawWord[15]}}, rawWord[15:0]};
         3'b010:  loadVal64 = {{32{rawWord[31]}}, rawWord[31:0]};
         3'b011:  loadVal64 = rawWord;
         3'b100:  loadVal64 = {56'd0, rawWord[7:0]};
         3'b101:  loadVal64 = {48'd0, rawWord[15:0]};
         3'b110:  loadVal64 = {32'd0, rawWord[31:0]};
         default: loadVal64 = '0;
      endcase
   end

   // Storage: byte-masked write at the completion edge; contents are not reset.
   always_ff @(posedge clk) begin
      if (doWrite) begin
         for (int i = 0; i < 8; i++) begin
            if (byteEn[i]) begin
               mem[opAddr + IDX_W'(i)] <= opData[8*i +: 8];
            end
         end
      end
   end

   // IDLE/BUSY control with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         opRead   <= 1'b0;
         opWrite  <= 1'b0;
         opFunct3 <= 3'b000;
         opAddr   <= '0;
         opData   <= '0;
         ready    <= 1'b1;
         valid    <= 1'b0;
         readData <= '0;
         error    <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= BUSY;
                  cnt      <= CNT_W'(LATENCY - 1);
                  opRead   <= memRead;
                  opWrite  <= memWrite;
                  opFunct3 <= funct3;
                  opAddr   <= address[IDX_W-1:0];
                  opData   <= 64'(writeData);
                  ready    <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= IDLE;
                  ready <= 1'b1;
                  valid <= 1'b1;
                  error <= reqError;
                  if (reqError) begin
                     readData <= '0;
                  end else if (opRead) begin
                     readData <= loadVal64[DATA_WIDTH-1:0];
                  end
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: three instances (LATENCY 1, 3, 4) share the data
// inputs; only the selected instance sees request strobes. Expected responses are
// queued when a request is driven and compared when that instance pulses valid.
module tb_data_memory_sized;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_D  = 3'b011;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;
   localparam logic [2:0] F_WU = 3'b110;
   localparam logic [2:0] F_XX = 3'b111;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } expT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [47:0] address;
   logic [63:0] writeData;
   int          sel;

   logic [2:0]  rdReq;
   logic [2:0]  wrReq;
   logic [2:0]  rdyV;
   logic [2:0]  vldV;
   logic [2:0]  errV;
   logic [63:0] rdV [3];

   logic        curReady;
   logic        curValid;
   logic        curErr;
   logic [63:0] curRd;

   expT         sbq [$];
   logic [63:0] lastData [3];
   string       curTag;
   int          nCompared = 0;
   int          nMismatch = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         rdReq[k] = memRead  && (sel == k);
         wrReq[k] = memWrite && (sel == k);
      end
      curReady = rdyV[sel];
      curValid = vldV[sel];
      curErr   = errV[sel];
      curRd    = rdV[sel];
   end

   data_memory_sized #(.LATENCY(1)) dutL1 (
      .clk(clk), .rst_n(rst_n), .memRead(rdReq[0]), .memWrite(wrReq[0]),
      .funct3(funct3), .address(address), .writeData(writeData),
      .ready(rdyV[0]), .valid(vldV[0]), .readData(rdV[0]), .error(errV[0]));

   data_memory_sized #(.LATENCY(3)) dutL3 (
      .clk(clk), .rst_n(rst_n), .memRead(rdReq[1]), .memWrite(wrReq[1]),
      .funct3(funct3), .address(address), .writeData(writeData),
      .ready(rdyV[1]), .valid(vldV[1]), .readData(rdV[1]), .error(errV[1]));

   data_memory_sized #(.LATENCY(4)) dutL4 (
      .clk(clk), .rst_n(rst_n), .memRead(rdReq[2]), .memWrite(wrReq[2]),
      .funct3(funct3), .address(address), .writeData(writeData),
      .ready(rdyV[2]), .valid(vldV[2]), .readData(rdV[2]), .error(errV[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Response monitor: every valid pulse of the selected instance consumes one entry.
   always @(negedge clk) begin : monitor
      expT e;
      if (rst_n && curValid) begin
         if (sbq.size() == 0) begin
            check({curTag, "/unexpected_valid"}, 64'(curValid), 64'd0);
         end else begin
            e = sbq.pop_front();
            check({curTag, "/data"}, curRd, e.data);
            check({curTag, "/err"}, 64'(curErr), 64'(e.err));
         end
      end
   end

   task automatic scramble();
      memRead   = 1'b0;
      memWrite  = 1'b0;
      funct3    = 3'($urandom);
      address   = {16'($urandom), $urandom};
      writeData = {$urandom, $urandom};
   endtask

   // Drive one request into instance s; queue its expected response when track is set.
   task automatic issue(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [47:0] a, input logic [63:0] wd, input logic [63:0] expData,
                        input logic expErr, input string tag, input bit track);
      expT e;
      int  n;
      sel = s;
      n   = 0;
      @(negedge clk);
      while (!curReady && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!curReady) begin
         check({tag, "/ready_timeout"}, 64'(curReady), 64'd1);
         return;
      end
      memRead   = rd;
      memWrite  = wr;
      funct3    = f3;
      address   = a;
      writeData = wd;
      curTag    = tag;
      if (track) begin
         if (expErr)         e.data = 64'd0;
         else if (wr && !rd) e.data = lastData[s];
         else                e.data = expData;
         e.err       = expErr;
         lastData[s] = e.data;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      scramble();
   endtask

   task automatic waitDone(input string tag);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         check({tag, "/response_timeout"}, 64'(sbq.size()), 64'd0);
         sbq.delete();
      end
   endtask

   task automatic ld(input int s, input logic [2:0] f3, input logic [47:0] a,
                     input logic [63:0] exp, input logic expErr, input string tag);
      issue(s, 1'b1, 1'b0, f3, a, {$urandom, $urandom}, exp, expErr, tag, 1'b1);
      waitDone(tag);
   endtask

   task automatic st(input int s, input logic [2:0] f3, input logic [47:0] a,
                     input logic [63:0] wd, input logic expErr, input string tag);
      issue(s, 1'b0, 1'b1, f3, a, wd, 64'd0, expErr, tag, 1'b1);
      waitDone(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      sel   = 0;
      curTag = "init";
      for (int k = 0; k < 3; k++) lastData[k] = 64'd0;
      scramble();
      repeat (3) @(negedge clk);
      check("reset/ready",    64'(curReady), 64'd1);
      check("reset/valid",    64'(curValid), 64'd0);
      check("reset/readData", curRd,         64'd0);
      check("reset/error",    64'(curErr),   64'd0);
      rst_n = 1'b1;

      // Reset while a store is in flight drops it.
      st(1, F_D, 48'h10, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, "t1_prefill");
      issue(1, 1'b0, 1'b1, F_D, 48'h10, 64'h1122_3344_5566_7788, 64'd0, 1'b0, "t1_abort", 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t1_rst/ready",    64'(curReady), 64'd1);
      check("t1_rst/valid",    64'(curValid), 64'd0);
      check("t1_rst/readData", curRd,         64'd0);
      check("t1_rst/error",    64'(curErr),   64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_rst/no_valid", 64'(curValid), 64'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) lastData[k] = 64'd0;
      ld(1, F_D, 48'h10, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, "t1_ld_after_reset");

      // Sizes and extension.
      st(0, F_D,  48'h20, 64'h8877_6655_4433_2211, 1'b0, "t2_sd");
      ld(0, F_B,  48'h27, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, "t2_lb");
      ld(0, F_BU, 48'h27, 64'h0000_0000_0000_0088, 1'b0, "t2_lbu");
      ld(0, F_H,  48'h22, 64'h0000_0000_0000_4433, 1'b0, "t2_lh");
      ld(0, F_H,  48'h26, 64'hFFFF_FFFF_FFFF_8877, 1'b0, "t2_lh_neg");
      ld(0, F_HU, 48'h26, 64'h0000_0000_0000_8877, 1'b0, "t2_lhu");
      ld(0, F_W,  48'h24, 64'hFFFF_FFFF_8877_6655, 1'b0, "t2_lw_neg");
      ld(0, F_WU, 48'h24, 64'h0000_0000_8877_6655, 1'b0, "t2_lwu");

      // Byte store touches one byte only; store response holds readData.
      st(0, F_B, 48'h21, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, "t3_sb");
      ld(0, F_D, 48'h20, 64'h8877_6655_4433_AB11, 1'b0, "t3_ld");

      // Rejected requests.
      ld(0, F_W, 48'h22, 64'd0, 1'b1, "t4_lw_misaligned");
      issue(0, 1'b1, 1'b1, F_D, 48'h20, 64'hDEAD_DEAD_DEAD_DEAD, 64'd0, 1'b1, "t4_rd_and_wr", 1'b1);
      waitDone("t4_rd_and_wr");
      st(0, F_H, 48'h21, 64'h0000_0000_0000_CAFE, 1'b1, "t4_sh_misaligned");
      ld(0, F_XX, 48'h20, 64'd0, 1'b1, "t4_funct3_111");
      ld(0, F_D, 48'h24, 64'd0, 1'b1, "t4_ld_misaligned");
      ld(0, F_D, 48'h20, 64'h8877_6655_4433_AB11, 1'b0, "t4_ld_unchanged");

      // Latency 4 timing.
      st(2, F_D, 48'h08, 64'h0123_4567_89AB_CDEF, 1'b0, "t5_sd");
      issue(2, 1'b1, 1'b0, F_D, 48'h08, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, "t5_ld", 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("t5_busy%0d/ready", k), 64'(curReady), 64'd0);
         check($sformatf("t5_busy%0d/valid", k), 64'(curValid), 64'd0);
      end
      @(negedge clk);
      check("t5_done/valid", 64'(curValid), 64'd1);
      check("t5_done/ready", 64'(curReady), 64'd1);
      waitDone("t5_ld");
      ld(2, F_W, 48'h0C, 64'h0000_0000_0123_4567, 1'b0, "t5_lw");

      // Address wrap modulo the array size.
      st(0, F_W,  48'h100, 64'h1234_5678_DEAD_BEEF, 1'b0, "t6_sw_wrap");
      ld(0, F_WU, 48'h000, 64'h0000_0000_DEAD_BEEF, 1'b0, "t6_lwu");
      ld(0, F_W,  48'h000, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, "t6_lw");
      ld(0, F_BU, 48'hFFFF_0000_0103, 64'h0000_0000_0000_00DE, 1'b0, "t6_lbu_high_addr");

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
